// File: rtl/score_display_driver_if.sv
// Game-state to display-driver bus: score/lives words in, display pins and converter status out.
// Pure wiring: no state and no latency.
// No backpressure: the inputs are level signals that the driver samples whenever it needs them.
interface score_display_driver_if;
  logic [31:0] playerScore;
  logic [31:0] playerLives;
  logic [7:0]  AN;
  logic [6:0]  SEVEN_SEG;
  logic        conv_busy;

  modport master (
    output playerScore,
    output playerLives,
    input  AN,
    input  SEVEN_SEG,
    input  conv_busy
  );

  modport slave (
    input  playerScore,
    input  playerLives,
    output AN,
    output SEVEN_SEG,
    output conv_busy
  );
endinterface

// File: rtl/score_display_driver.sv
// Decimal score/lives readout on an 8-digit multiplexed seven-segment display.
// Latency: 16-cycle conversion period, display regs follow a score change within 32 cycles.
// No backpressure: the score is re-sampled every period; mid-conversion changes wait for the next one.
module score_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int LIVES_AN    = 4
) (
  input logic                   clk,
  input logic                   reset,
  score_display_driver_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [2:0]    LIVES_POS    = 3'(LIVES_AN);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [3:0]  shift_cnt;
  logic        busy;
  logic [15:0] disp_bcd;

  logic [CW-1:0] refresh_cnt;
  logic [2:0]    digit_idx;
  logic [7:0]    an_q;
  logic [6:0]    seg_q;

  // Scores above four digits saturate so the display never wraps.
  logic [13:0] score_sat;
  logic [3:0]  lives_val;
  assign score_sat = (bus.playerScore > 32'd9999) ? 14'd9999 : bus.playerScore[13:0];
  assign lives_val = (bus.playerLives > 32'd9) ? 4'd9 : bus.playerLives[3:0];

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [15:0] add3(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low {g..a} patterns; anything non-decimal shows blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  logic [15:0] bcd_adj;
  assign bcd_adj = add3(bcd);

  // Converter FSM: capture, 14 shift steps, then atomic publish to the display regs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bin       <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
      busy      <= 1'b0;
      disp_bcd  <= '0;
    end else begin
      case (state)
        IDLE: begin
          bin       <= score_sat;
          bcd       <= '0;
          shift_cnt <= '0;
          busy      <= 1'b1;
          state     <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          shift_cnt  <= shift_cnt + 4'd1;
          if (shift_cnt == 4'd13) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          disp_bcd <= bcd;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Digit select, leading-zero blanking and anode pattern for the current scan slot.
  logic [3:0] cur_nib;
  logic       cur_blank;
  logic [2:0] an_pos;
  logic [7:0] an_next;
  always_comb begin
    cur_nib   = 4'hF;
    cur_blank = 1'b0;
    an_pos    = digit_idx;
    case (digit_idx)
      3'd0: cur_nib = disp_bcd[3:0];
      3'd1: begin
        cur_nib   = disp_bcd[7:4];
        cur_blank = (disp_bcd[15:4] == 12'd0);
      end
      3'd2: begin
        cur_nib   = disp_bcd[11:8];
        cur_blank = (disp_bcd[15:8] == 8'd0);
      end
      3'd3: begin
        cur_nib   = disp_bcd[15:12];
        cur_blank = (disp_bcd[15:12] == 4'd0);
      end
      3'd4: begin
        cur_nib = lives_val;
        an_pos  = LIVES_POS;
      end
      default: cur_blank = 1'b1;
    endcase
    an_next         = 8'hFF;
    an_next[an_pos] = 1'b0;
  end

  // Refresh scanner: each digit stays lit REFRESH_DIV cycles; outputs are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      an_q        <= 8'hFF;
      seg_q       <= 7'h7F;
    end else begin
      an_q  <= an_next;
      seg_q <= cur_blank ? 7'h7F : seg7(cur_nib);
      if (refresh_cnt == REFRESH_LAST) begin
        refresh_cnt <= '0;
        digit_idx   <= (digit_idx == 3'd4) ? 3'd0 : digit_idx + 3'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

  assign bus.AN        = an_q;
  assign bus.SEVEN_SEG = seg_q;
  assign bus.conv_busy = busy;

endmodule

// File: tb/tb_score_display_driver.sv
// Directed bench for score_display_driver with a fast refresh divider.
// Observes outputs on the falling clock edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_score_display_driver;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  score_display_driver_if bus ();

  score_display_driver #(
    .REFRESH_DIV(4),
    .LIVES_AN   (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Locks onto the start of slot 0 and checks one full 20-cycle scan.
  task automatic check_scan(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3, input logic [6:0] e4);
    logic [7:0] exp_an [5];
    logic [6:0] exp_seg[5];
    logic [7:0] prev_an;
    int         guard;
    exp_an[0] = 8'hFE; exp_an[1] = 8'hFD; exp_an[2] = 8'hFB; exp_an[3] = 8'hF7; exp_an[4] = 8'hEF;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3; exp_seg[4] = e4;
    prev_an = bus.AN;
    tick();
    guard = 0;
    while (!(bus.AN == 8'hFE && prev_an != 8'hFE) && guard < 60) begin
      prev_an = bus.AN;
      tick();
      guard++;
    end
    if (guard >= 60) begin
      check({tag, "_sync_timeout"}, 32'd1, 32'd0);
    end else begin
      for (int i = 0; i < 20; i++) begin
        check($sformatf("%s_an%0d", tag, i), {24'd0, bus.AN}, {24'd0, exp_an[i/4]});
        check($sformatf("%s_seg%0d", tag, i), {25'd0, bus.SEVEN_SEG}, {25'd0, exp_seg[i/4]});
        tick();
      end
    end
  endtask

  task automatic wait_busy(input logic level, input string tag);
    int guard;
    guard = 0;
    while (bus.conv_busy !== level && guard < 40) begin
      tick();
      guard++;
    end
    if (guard >= 40) check({tag, "_busy_timeout"}, 32'd1, 32'd0);
  endtask

  // Runs one conversion from its first busy cycle through DONE; optional score change at busy cycle 3.
  task automatic conv(input logic do_change, input logic [31:0] new_score, input string tag,
                      output int hi, output int lo);
    wait_busy(1'b1, tag);
    hi = 0;
    while (bus.conv_busy === 1'b1 && hi < 40) begin
      hi++;
      if (do_change && hi == 3) bus.playerScore = new_score;
      tick();
    end
    lo = 0;
    while (bus.conv_busy === 1'b0 && lo < 40) begin
      lo++;
      tick();
    end
  endtask

  int hi;
  int lo;

  initial begin
    compared        = 0;
    mismatched      = 0;
    reset           = 1'b0;
    bus.playerScore = 32'd1234;
    bus.playerLives = 32'd3;

    // Reset values while held.
    repeat (5) tick();
    check("rst_an", {24'd0, bus.AN}, 32'h000000FF);
    check("rst_seg", {25'd0, bus.SEVEN_SEG}, 32'h0000007F);
    check("rst_busy", {31'd0, bus.conv_busy}, 32'd0);

    // First edge after release drives slot 0 from the cleared display regs.
    reset = 1'b1;
    tick();
    check("rel_an", {24'd0, bus.AN}, 32'h000000FE);
    check("rel_seg", {25'd0, bus.SEVEN_SEG}, 32'h00000040);
    check("rel_busy", {31'd0, bus.conv_busy}, 32'd1);

    // 1234 with 3 lives.
    repeat (40) tick();
    check_scan("s1234", 7'h19, 7'h30, 7'h24, 7'h79, 7'h30);

    // Leading-zero blanking.
    bus.playerScore = 32'd7;
    bus.playerLives = 32'd0;
    repeat (40) tick();
    check_scan("s7", 7'h78, 7'h7F, 7'h7F, 7'h7F, 7'h40);

    // Saturation of score and lives.
    bus.playerScore = 32'h80000005;
    bus.playerLives = 32'd12;
    repeat (40) tick();
    check_scan("sat", 7'h10, 7'h10, 7'h10, 7'h10, 7'h10);

    // Score change during SHIFT is deferred to the following conversion.
    bus.playerScore = 32'd500;
    wait_busy(1'b0, "mid_pre");
    conv(1'b1, 32'd42, "mid1", hi, lo);
    check("mid1_disp", {16'd0, dut.disp_bcd}, 32'h00000500);
    check("mid1_hi", hi, 32'd14);
    check("mid1_lo", lo, 32'd2);
    conv(1'b0, 32'd0, "mid2", hi, lo);
    check("mid2_disp", {16'd0, dut.disp_bcd}, 32'h00000042);
    check("mid2_hi", hi, 32'd14);
    check("mid2_lo", lo, 32'd2);

    // Asynchronous reset between edges in the middle of SHIFT.
    wait_busy(1'b1, "ar_pre");
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("ar_an", {24'd0, bus.AN}, 32'h000000FF);
    check("ar_seg", {25'd0, bus.SEVEN_SEG}, 32'h0000007F);
    check("ar_busy", {31'd0, bus.conv_busy}, 32'd0);
    check("ar_disp", {16'd0, dut.disp_bcd}, 32'd0);
    repeat (2) tick();
    bus.playerScore = 32'd1234;
    reset = 1'b1;
    conv(1'b0, 32'd0, "ar_conv", hi, lo);
    check("ar_conv_disp", {16'd0, dut.disp_bcd}, 32'h00001234);
    check("ar_conv_hi", hi, 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
